lockin_accumulate: RTL
======================

# lockin_accumulate

Downstream consumer of the lock-in multiplier stream. Integrates the in-phase and quadrature product streams (64-bit signed, one pair per valid) over an integer number of reference cycles (ptos_x_ciclo × ciclos samples). It emits one scaled, saturated sum pair per window. The block sits between the reference multiplier and the register/FIFO readout that delivers X/Y lock-in results to the host.

## Interface
- ACC_W, 96, internal accumulator width (signed); must be ≥ 64 + 32.
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low; clears all state and outputs.
- enable  in  1  when low, input samples are ignored and state/counters hold.
- ptos_x_ciclo  in  16  points per reference cycle M; latched on start; 0 is treated as 1.
- ciclos  in  16  reference cycles per window K; latched on start; 0 is treated as 1.
- shift  in  7  arithmetic right shift applied to sums at dump (0..127); latched on start.
- continuous  in  1  1: restart a new window automatically after each dump; sampled at dump.
- start  in  1  single-cycle request to begin a window; only honoured in IDLE with enable=1.
- data_in_seno  in  64  signed in-phase product.
- data_in_coseno  in  64  signed quadrature product.
- data_valid_in  in  1  qualifies both data inputs for the current cycle.
- data_out_fase  out  64  signed scaled in-phase sum; reset 0; holds until next dump.
- data_out_cuad  out  64  signed scaled quadrature sum; reset 0; holds until next dump.
- data_valid_out  out  1  one-cycle pulse when outputs update; reset 0.
- busy  out  1  high in ACUM and DUMP; reset 0.
- overflow  out  1  sticky saturation flag; reset 0; cleared on an accepted start.

## Operation
- N = M_eff × K_eff (32-bit unsigned product), computed and latched on start.
- States: IDLE, ACUM, DUMP.
- IDLE: busy=0. On start & enable:
  - latch N and shift;
  - clear both accumulators, sample counter and overflow;
  - go to ACUM.
  - Data is ignored in IDLE.
- ACUM: each cycle with enable & data_valid_in:
  - acc_s += sign-extended data_in_seno; acc_c += sign-extended data_in_coseno; cnt++.
  - When the accepted sample is the N-th (cnt == N−1 before the increment), the sums including that sample are final; go to DUMP.
  - start is ignored.
- DUMP (exactly one cycle):
  - r = acc >>> shift (arithmetic) for each channel.
  - If r > 2^63−1, output 2^63−1; if r < −2^63, output −2^63. Either case sets overflow.
  - Otherwise output r[63:0].
  - Register both outputs and assert data_valid_out on the following cycle.
  - If continuous=1: go to ACUM with fresh window; N and shift are re-used (not re-latched).
    - A valid sample presented in the DUMP cycle (with enable) becomes sample 1 of the new window: acc = that sample, cnt = 1.
    - If N = 1 in that case, the next state is DUMP again.
  - If continuous=0: go to IDLE; a sample presented in the DUMP cycle is dropped.
- Accumulators never wrap for N ≤ 2^32 (ACC_W ≥ 96); saturation only occurs at output scaling.
- Input config changes (ptos_x_ciclo, ciclos, shift) while busy have no effect until the next start.
- enable low in any state: freezes state, cnt and accumulators. A pending DUMP still completes, because dump does not depend on enable.

## Timing
- Last sample of a window accepted in cycle c → DUMP in cycle c+1 → data_valid_out=1 and new outputs visible in cycle c+2, for exactly one cycle.
- Continuous mode with data_valid_in high every cycle: no sample is lost. One dump occurs per N samples; output pulses are spaced exactly N cycles apart.
- busy rises the cycle after the accepted start and falls the cycle after DUMP (single mode).
- Asynchronous reset mid-window:
  - immediate return to IDLE;
  - all outputs 0, busy 0, overflow 0;
  - no data_valid_out is generated for the aborted window.

## Test plan
- M=4, K=2, shift=0, start, then 8 valids with seno=10, coseno=−3 → single pulse 2 cycles after 8th sample: fase=80, cuad=−24; busy low next cycle; overflow=0.
- Same as above with valid gaps and enable low for 3 cycles mid-window → identical outputs; pulse timing relative to 8th accepted sample unchanged.
- continuous=1, M=4, K=1, valid every cycle with seno=1,2,3,…,12 → three pulses 4 cycles apart: fase=10, 26, 42; value arriving in DUMP cycle counted.
- M=2, K=2, seno=2^62 ×4, shift=0 → fase=2^63−1, overflow=1. Repeat with shift=2 → fase=2^62, overflow=0 after new start.
- Reset asserted after 3 of 8 samples → outputs 0, busy 0, no pulse. New start with 8 samples of 5 → fase=40.
- ptos_x_ciclo=0, ciclos=0, single sample seno=−7 → window of 1: fase=−7, pulse 2 cycles later.

Source files
------------

// File: rtl/lockin_accumulate_if.sv
// Sample stream into the lock-in accumulator and scaled X/Y results out of it.
// The producer/readout side uses master, the accumulator uses slave.
interface lockin_accumulate_if;
    logic signed [63:0] data_in_seno;
    logic signed [63:0] data_in_coseno;
    logic               data_valid_in;
    logic signed [63:0] data_out_fase;
    logic signed [63:0] data_out_cuad;
    logic               data_valid_out;

    modport master (
        output data_in_seno, data_in_coseno, data_valid_in,
        input  data_out_fase, data_out_cuad, data_valid_out
    );

    modport slave (
        input  data_in_seno, data_in_coseno, data_valid_in,
        output data_out_fase, data_out_cuad, data_valid_out
    );
endinterface

// File: rtl/lockin_accumulate.sv
// Integrates I/Q product streams over ptos_x_ciclo*ciclos samples and emits one
// scaled, saturated sum pair per window; optional back-to-back windows.
module lockin_accumulate #(
    parameter int ACC_W = 96
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [15:0]           ptos_x_ciclo,
    input  logic [15:0]           ciclos,
    input  logic [6:0]            shift,
    input  logic                  continuous,
    input  logic                  start,
    lockin_accumulate_if.slave    stream,
    output logic                  busy,
    output logic                  overflow
);

    typedef enum logic [1:0] {IDLE, ACUM, DUMP} state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-63){1'b0}}, {63{1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-63){1'b1}}, {63{1'b0}}};

    state_t                   state, state_next;
    logic [31:0]              n_lat;
    logic [6:0]               shift_lat;
    logic [31:0]              cnt;
    logic signed [ACC_W-1:0]  acc_s, acc_c;
    logic signed [63:0]       fase_q, cuad_q;
    logic                     valid_q;

    logic [15:0]              m_eff, k_eff;
    logic [31:0]              n_calc;
    logic                     accept, last;
    logic signed [ACC_W-1:0]  seno_ext, coseno_ext;
    logic signed [ACC_W-1:0]  r_s, r_c;
    logic signed [63:0]       sat_s, sat_c;
    logic                     ovf_s, ovf_c;

    always_comb begin
        m_eff      = (ptos_x_ciclo == 16'd0) ? 16'd1 : ptos_x_ciclo;
        k_eff      = (ciclos == 16'd0) ? 16'd1 : ciclos;
        n_calc     = 32'(m_eff) * 32'(k_eff);
        accept     = enable && stream.data_valid_in;
        last       = (cnt == n_lat - 32'd1);
        seno_ext   = {{(ACC_W-64){stream.data_in_seno[63]}}, stream.data_in_seno};
        coseno_ext = {{(ACC_W-64){stream.data_in_coseno[63]}}, stream.data_in_coseno};
    end

    // Scaling and clamping to the 64-bit signed output range.
    always_comb begin
        r_s   = acc_s >>> shift_lat;
        r_c   = acc_c >>> shift_lat;
        ovf_s = 1'b0;
        ovf_c = 1'b0;
        sat_s = r_s[63:0];
        sat_c = r_c[63:0];
        if (r_s > SAT_MAX) begin
            sat_s = 64'sh7FFF_FFFF_FFFF_FFFF;
            ovf_s = 1'b1;
        end else if (r_s < SAT_MIN) begin
            sat_s = 64'sh8000_0000_0000_0000;
            ovf_s = 1'b1;
        end
        if (r_c > SAT_MAX) begin
            sat_c = 64'sh7FFF_FFFF_FFFF_FFFF;
            ovf_c = 1'b1;
        end else if (r_c < SAT_MIN) begin
            sat_c = 64'sh8000_0000_0000_0000;
            ovf_c = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start && enable) state_next = ACUM;
            ACUM: if (accept && last) state_next = DUMP;
            DUMP: begin
                // A sample taken during DUMP opens the next window; with N=1 it closes it too.
                if (continuous)
                    state_next = (accept && n_lat == 32'd1) ? DUMP : ACUM;
                else
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            n_lat     <= '0;
            shift_lat <= '0;
            cnt       <= '0;
            acc_s     <= '0;
            acc_c     <= '0;
            fase_q    <= '0;
            cuad_q    <= '0;
            valid_q   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && enable) begin
                        n_lat     <= n_calc;
                        shift_lat <= shift;
                        cnt       <= '0;
                        acc_s     <= '0;
                        acc_c     <= '0;
                        overflow  <= 1'b0;
                    end
                end
                ACUM: begin
                    if (accept) begin
                        acc_s <= acc_s + seno_ext;
                        acc_c <= acc_c + coseno_ext;
                        cnt   <= cnt + 32'd1;
                    end
                end
                DUMP: begin
                    fase_q  <= sat_s;
                    cuad_q  <= sat_c;
                    valid_q <= 1'b1;
                    if (ovf_s || ovf_c) overflow <= 1'b1;
                    if (continuous && accept) begin
                        acc_s <= seno_ext;
                        acc_c <= coseno_ext;
                        cnt   <= 32'd1;
                    end else begin
                        acc_s <= '0;
                        acc_c <= '0;
                        cnt   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy                  = (state != IDLE);
    assign stream.data_out_fase  = fase_q;
    assign stream.data_out_cuad  = cuad_q;
    assign stream.data_valid_out = valid_q;

endmodule
